// File: rtl/gpu_isa_pkg.sv
// Shared GPU ISA types: opcode and instruction encodings plus the fetch FSM state enum.
// An instruction word is opcode[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0].
package gpu_isa_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    MOV  = 4'h3,
    LD   = 4'h4,
    ST   = 4'h5,
    BR   = 4'h6,
    HALT = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } instruction_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } fetch_state_t;

endpackage

// File: rtl/gpu_fetch_unit.sv
// Instruction fetch unit: a single-entry instruction buffer in front of instruction memory,
// with at most one outstanding request and stale-response tracking for redirects and flushes.
module gpu_fetch_unit
  import gpu_isa_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output instruction_t           instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   busy
);

  if (INSTR_WIDTH != $bits(instruction_t)) begin : g_width_check
    $error("INSTR_WIDTH must equal $bits(instruction_t)");
  end

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_pc_q, cur_pc_d;
  logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  stale_q, stale_d;
  instruction_t          buf_data_q, buf_data_d;
  logic                  pc_match;
  logic                  stale_now;

  assign pc_match = (pc_in == cur_pc_q);
  // A response is stale if a redirect or flush was seen at any point since the request.
  assign stale_now = stale_q | flush | ~pc_match;

  always_comb begin
    state_d     = state_q;
    cur_pc_d    = cur_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    stale_d     = stale_q;
    buf_data_d  = buf_data_q;
    if (flush) buf_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          cur_pc_d = pc_in;
          if (buf_valid_q && !flush && (pc_in == buf_pc_q)) state_d = S_VALID;
          else                                             state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The request stays asserted across a flush; its response is then discarded.
        if (flush) stale_d = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (stale_now) begin
            stale_d  = 1'b0;
            cur_pc_d = pc_in;
            state_d  = S_REQ;
          end else begin
            buf_data_d  = instruction_t'(imem_rsp_data);
            buf_pc_d    = cur_pc_q;
            buf_valid_d = 1'b1;
            state_d     = S_VALID;
          end
        end else if (stale_now) begin
          stale_d = 1'b1;
        end
      end
      S_VALID: begin
        if (!pc_match || flush) state_d = S_IDLE;
        else if (instr_ready)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_pc_q    <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      stale_q     <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_pc_q    <= cur_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      stale_q     <= stale_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = cur_pc_q;
  assign busy           = (state_q != S_IDLE);
  // Only the presentation is qualified combinationally by the live pc and flush.
  assign instr_valid    = (state_q == S_VALID) && pc_match && !flush;
  assign instr_out      = instr_valid ? buf_data_q : '0;

endmodule
